// File: rtl/regfile_mp.sv
// Multi-port register file: NRD registered read ports with write bypass, two
// prioritised write ports, optional hardwired zero register and a pending-write scoreboard.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD-1:0]       re,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*WIDTH-1:0] rdata,
    output logic [NRD-1:0]       rpend,
    input  logic                 we0,
    input  logic [AW-1:0]        waddr0,
    input  logic [WIDTH-1:0]     wdata0,
    input  logic                 we1,
    input  logic [AW-1:0]        waddr1,
    input  logic [WIDTH-1:0]     wdata1,
    input  logic                 mark_en,
    input  logic [AW-1:0]        mark_addr,
    output logic                 pend_any
);

    localparam logic HAS_ZERO = (ZERO_REG != 0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pend_nxt;
    logic             we0_eff;
    logic             we1_eff;
    logic             mark_eff;

    // Anything aimed at the zero register is dropped before it reaches state.
    assign we0_eff  = we0     && !(HAS_ZERO && (waddr0 == '0));
    assign we1_eff  = we1     && !(HAS_ZERO && (waddr1 == '0));
    assign mark_eff = mark_en && !(HAS_ZERO && (mark_addr == '0));

    // A new mark supersedes a retiring producer on the same register.
    always_comb begin
        pend_nxt = pending;
        if (we0_eff) pend_nxt[waddr0] = 1'b0;
        if (we1_eff) pend_nxt[waddr1] = 1'b0;
        if (mark_eff) pend_nxt[mark_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            pending <= '0;
        end else begin
            if (we0_eff) mem[waddr0] <= wdata0;
            if (we1_eff) mem[waddr1] <= wdata1;
            pending <= pend_nxt;
        end
    end

    assign pend_any = |pending;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] byp_d;
        logic             byp_p;
        logic [WIDTH-1:0] q_d;
        logic             q_p;

        assign ra = raddr[k*AW +: AW];

        // Port 1 is applied last so it wins an equal-address collision.
        always_comb begin
            byp_d = mem[ra];
            byp_p = pend_nxt[ra];
            if (we0_eff && (waddr0 == ra)) byp_d = wdata0;
            if (we1_eff && (waddr1 == ra)) byp_d = wdata1;
            if (HAS_ZERO && (ra == '0)) begin
                byp_d = '0;
                byp_p = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                q_d <= '0;
                q_p <= 1'b0;
            end else if (re[k]) begin
                q_d <= byp_d;
                q_p <= byp_p;
            end
        end

        assign rdata[k*WIDTH +: WIDTH] = q_d;
        assign rpend[k]                = q_p;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios followed by random traffic, checked
// against an array-based model of the register file and scoreboard.
module tb_regfile_mp;
    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;

    logic                 clk;
    logic                 rst;
    logic [NRD-1:0]       re;
    logic [NRD*AW-1:0]    raddr;
    logic [NRD*WIDTH-1:0] rdata;
    logic [NRD-1:0]       rpend;
    logic                 we0;
    logic [AW-1:0]        waddr0;
    logic [WIDTH-1:0]     wdata0;
    logic                 we1;
    logic [AW-1:0]        waddr1;
    logic [WIDTH-1:0]     wdata1;
    logic                 mark_en;
    logic [AW-1:0]        mark_addr;
    logic                 pend_any;

    regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .NRD(NRD), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .re(re), .raddr(raddr), .rdata(rdata), .rpend(rpend),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .mark_en(mark_en), .mark_addr(mark_addr), .pend_any(pend_any)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // reference model state
    logic [WIDTH-1:0] m_reg [DEPTH];
    logic             m_pend [DEPTH];
    logic [WIDTH-1:0] m_rdata [NRD];
    logic             m_rpend [NRD];
    logic [WIDTH-1:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
        for (int k = 0; k < NRD; k++) begin
            m_rdata[k] = '0;
            m_rpend[k] = 1'b0;
        end
    endtask

    // One clock edge of architectural behaviour: writes in port order, then marks, then reads.
    task automatic model_edge();
        int a;
        if (!rst) begin
            model_reset();
        end else begin
            if (we0 && waddr0 != 0) begin
                m_reg[waddr0]  = wdata0;
                m_pend[waddr0] = 1'b0;
            end
            if (we1 && waddr1 != 0) begin
                m_reg[waddr1]  = wdata1;
                m_pend[waddr1] = 1'b0;
            end
            if (mark_en && mark_addr != 0) m_pend[mark_addr] = 1'b1;
            for (int k = 0; k < NRD; k++) begin
                a = int'(raddr[k*AW +: AW]);
                if (re[k]) begin
                    m_rdata[k] = (a == 0) ? '0 : m_reg[a];
                    m_rpend[k] = (a == 0) ? 1'b0 : m_pend[a];
                end
            end
        end
        for (int k = 0; k < NRD; k++) exp_q.push_back(m_rdata[k]);
    endtask

    function automatic logic model_pend_any();
        logic any = 1'b0;
        for (int i = 0; i < DEPTH; i++) any |= m_pend[i];
        return any;
    endfunction

    task automatic check_all();
        logic [WIDTH-1:0] e;
        for (int k = 0; k < NRD; k++) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL exp_q_empty obs=0 exp=1");
            end else begin
                e = exp_q.pop_front();
                check($sformatf("rdata%0d", k), rdata[k*WIDTH +: WIDTH], e);
            end
            check($sformatf("rpend%0d", k), {31'b0, rpend[k]}, {31'b0, m_rpend[k]});
        end
        check("pend_any", {31'b0, pend_any}, {31'b0, model_pend_any()});
    endtask

    // driver tasks
    task automatic drive_idle();
        re = '0; raddr = '0;
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        mark_en = 1'b0; mark_addr = '0;
    endtask

    task automatic drive_w0(input int a, input logic [WIDTH-1:0] d);
        we0 = 1'b1; waddr0 = AW'(a); wdata0 = d;
    endtask

    task automatic drive_w1(input int a, input logic [WIDTH-1:0] d);
        we1 = 1'b1; waddr1 = AW'(a); wdata1 = d;
    endtask

    task automatic drive_mark(input int a);
        mark_en = 1'b1; mark_addr = AW'(a);
    endtask

    task automatic drive_read(input int k, input int a);
        re[k] = 1'b1; raddr[k*AW +: AW] = AW'(a);
    endtask

    // Inputs are set at posedge+1; the edge is modelled, then outputs are checked at posedge+1.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b0;
        drive_idle();
        model_reset();

        // reset state and zero register
        #3;
        check("rst_rdata0", rdata[0 +: WIDTH], '0);
        check("rst_pend_any", {31'b0, pend_any}, '0);
        tick();
        rst = 1'b1;
        drive_idle(); drive_w0(0, 32'hDEADBEEF); tick();
        drive_idle(); drive_read(0, 0); tick();
        check("zero_reg", rdata[0 +: WIDTH], 32'h0);

        // basic write then read, then hold with re=0
        drive_idle(); drive_w0(5, 32'h12345678); tick();
        drive_idle(); drive_read(0, 5); tick();
        check("basic_read", rdata[0 +: WIDTH], 32'h12345678);
        drive_idle(); drive_w0(5, 32'hCAFEF00D); tick();
        check("hold_re0", rdata[0 +: WIDTH], 32'h12345678);

        // same-edge bypass and collision
        drive_idle(); drive_w0(7, 32'hAAAA0000); drive_read(1, 7); tick();
        check("bypass_w0", rdata[WIDTH +: WIDTH], 32'hAAAA0000);
        drive_idle(); drive_w0(9, 32'h1); drive_w1(9, 32'h2); drive_read(0, 9); tick();
        check("collide_byp", rdata[0 +: WIDTH], 32'h2);
        drive_idle(); drive_read(1, 9); tick();
        check("collide_store", rdata[WIDTH +: WIDTH], 32'h2);

        // scoreboard set / clear
        drive_idle(); drive_mark(3); tick();
        check("mark_any", {31'b0, pend_any}, 32'h1);
        drive_idle(); drive_read(0, 3); tick();
        check("mark_rpend", {31'b0, rpend[0]}, 32'h1);
        drive_idle(); drive_w1(3, 32'h55); drive_read(0, 3); tick();
        check("clear_rdata", rdata[0 +: WIDTH], 32'h55);
        check("clear_rpend", {31'b0, rpend[0]}, 32'h0);

        // mark and write same register: set wins
        drive_idle(); drive_mark(4); drive_w0(4, 32'h9); drive_read(1, 4); tick();
        check("setwins_data", rdata[WIDTH +: WIDTH], 32'h9);
        check("setwins_pend", {31'b0, rpend[1]}, 32'h1);

        // duplicate read addresses
        drive_idle(); drive_read(0, 4); drive_read(1, 4); tick();

        // async reset mid-operation
        drive_idle(); drive_w0(6, 32'h66); drive_mark(6); tick();
        drive_idle(); drive_read(0, 6); drive_read(1, 6); drive_w1(8, 32'h88); drive_mark(10); tick();
        #2;
        rst = 1'b0;
        #1;
        check("async_rdata0", rdata[0 +: WIDTH], '0);
        check("async_rdata1", rdata[WIDTH +: WIDTH], '0);
        check("async_rpend", {30'b0, rpend}, '0);
        check("async_pend_any", {31'b0, pend_any}, '0);
        tick();
        rst = 1'b1;
        drive_idle(); drive_read(0, 6); drive_read(1, 8); tick();
        check("post_rst_r6", rdata[0 +: WIDTH], '0);

        // random traffic; small address window most of the time to force collisions
        for (int n = 0; n < 600; n++) begin
            drive_idle();
            re = NRD'($urandom_range(0, (1 << NRD) - 1));
            for (int k = 0; k < NRD; k++)
                raddr[k*AW +: AW] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 7));
            we0 = 1'($urandom_range(0, 1));
            waddr0 = AW'($urandom_range(0, 7));
            wdata0 = $urandom;
            we1 = 1'($urandom_range(0, 1));
            waddr1 = AW'(($urandom_range(0, 3) == 0) ? waddr0 : AW'($urandom_range(0, 7)));
            wdata1 = $urandom;
            mark_en = 1'($urandom_range(0, 2) == 0);
            mark_addr = AW'($urandom_range(0, 7));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file for the pipelined MIPS core. It supersedes the single-write, two-read register file. It provides:
- NRD registered read ports and two write ports with deterministic collision priority.
- Write-to-read bypass and a hardwired zero register.
- A per-register pending-write scoreboard used by decode for load-use hazard detection.

Parameters:
WIDTH, 32, data width of each register
DEPTH, 32, number of registers (power of two, >=2)
AW, 5, address width, equals log2(DEPTH)
NRD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never pending

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset
re  input  NRD  per-port read enable
raddr  input  NRD*AW  read addresses, port k at bits [k*AW +: AW]
rdata  output  NRD*WIDTH  registered read data, port k at [k*WIDTH +: WIDTH]
rpend  output  NRD  registered pending flag for the register read on port k
we0  input  1  write enable, port 0 (ALU writeback)
waddr0  input  AW  write address, port 0
wdata0  input  WIDTH  write data, port 0
we1  input  1  write enable, port 1 (memory/load writeback)
waddr1  input  AW  write address, port 1
wdata1  input  WIDTH  write data, port 1
mark_en  input  1  set pending bit of mark_addr (decode issues a load)
mark_addr  input  AW  register to mark pending
pend_any  output  1  OR of all pending bits, combinational from state

Behaviour:
- Reset: asynchronous, active-low (rst=0). All registers, rdata, rpend and pending bits clear to 0 immediately. pend_any=0. Deassertion takes effect at the next rising edge.
- Write: on posedge, if weN=1, reg[waddrN] <= wdataN.
  - If we0 and we1 are both 1 with equal addresses, port 1 wins.
  - Different addresses: both writes commit.
- Zero register (ZERO_REG=1): writes and marks to address 0 are dropped. Reads of address 0 return 0 with rpend=0.
- Read latency is 1 cycle. At posedge with re[k]=1, rdata[k] <= value of reg[raddr[k]] as it is after this edge's writes (bypass). Bypass rules:
  - Matching write from port 1: wdata1 is returned.
  - Else matching write from port 0: wdata0 is returned.
  - Else the stored value is returned.
- re[k]=0: rdata[k] and rpend[k] hold their previous values.
- Scoreboard, pending[DEPTH], updated per posedge:
  - Clear: pending[a]=0 for each a equal to an active waddr0/waddr1.
  - Set: pending[mark_addr]=1 when mark_en=1. A set on the same address as a clear in the same cycle wins, because the new producer supersedes the old one.
- rpend[k] <= post-update pending[raddr[k]] when re[k]=1, i.e. the same bypass semantics as data.
- pend_any reflects the current pending state (registered bits ORed).
- Out-of-range addresses cannot occur, since DEPTH=2^AW.
- Duplicate read addresses across ports return identical data.
- Reset mid-operation: all in-flight writes and marks in that cycle are discarded.

Test Plan:
1. Reset/zero register: hold rst=0 and pulse clk → rdata=0, rpend=0, pend_any=0. Then write 0xDEADBEEF to r0 and read r0 → rdata=0.
2. Basic write/read: we0 writes r5=0x12345678. Next cycle read raddr[0]=5 with re=1 → after one edge rdata[0]=0x12345678. With re=0 and r5 rewritten, rdata[0] stays 0x12345678.
3. Same-cycle bypass and collision, in the same edge:
   - Without collision: we0 writes r7=0xAAAA0000 while re[1]=1, raddr[1]=7 → rdata[1]=0xAAAA0000.
   - With collision: we0 r9=0x1 and we1 r9=0x2 → r9=0x2, and a same-edge read of r9 returns 0x2.
4. Scoreboard: mark_en r3 → pend_any=1. Read r3 → rpend=1. Then we1 r3=0x55 → pending clears; a same-edge read returns rdata=0x55, rpend=0.
5. Mark/clear conflict: in the same cycle, mark_en r4 and we0 r4=0x9 → r4=0x9 and pending[4]=1 (set wins).
6. Async reset mid-operation: with r6 pending and nonzero, drop rst between clock edges → rdata, rpend and pend_any go to 0 before the next edge. A subsequent read of r6 returns 0.
